// File: rtl/fv_req_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fv_req_arbiter_pkg
// Description : Shared definitions for the FV request arbiter. Holds the Edge
//               PE count, the FV FIFO word layout and the arbiter state
//               encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package fv_req_arbiter_pkg;

    // Number of Edge PE requesters in the default system build
    localparam int NUM_EDGE_PE  = 4;
    localparam int FV_ADDR_W    = 8;
    localparam int FV_TAG_W     = $clog2(NUM_EDGE_PE);
    localparam int ISSUED_CNT_W = 16;

    // Word written into the FV FIFO: {valid, FV_addr, PE_tag}
    typedef struct packed {
        logic                 valid;
        logic [FV_ADDR_W-1:0] fv_addr;
        logic [FV_TAG_W-1:0]  pe_tag;
    } fv_info2fv_fifo_t;

    // Arbiter control states
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } arb_state_e;

endpackage : fv_req_arbiter_pkg
`default_nettype wire

// File: rtl/fv_req_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module      : fv_req_arbiter_rr_pick
// Description : Combinational round-robin picker. Scans ptr..num_active-1,
//               then 0..ptr-1, and returns the first set request. A pointer
//               at or beyond num_active restarts the scan at 0. num_active
//               must already be in the range 1..NUM_REQ.
// Revision    : 1.0 - initial release
// ============================================================================
module fv_req_arbiter_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int TAG_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_mask,
    input  logic [TAG_W-1:0]   ptr,
    input  logic [TAG_W:0]     num_active,
    output logic [TAG_W-1:0]   grant_idx,
    output logic               found
);

    // Rotating first-set search bounded to the active requester window
    always_comb begin
        int start;
        int cand;
        grant_idx = '0;
        found     = 1'b0;
        start     = ({1'b0, ptr} >= num_active) ? 0 : int'(ptr);
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = start + k;
            if (cand >= int'(num_active)) begin
                cand = cand - int'(num_active);
            end
            if (!found && (k < int'(num_active)) && (cand < NUM_REQ)) begin
                if (req_mask[cand]) begin
                    found     = 1'b1;
                    grant_idx = TAG_W'(cand);
                end
            end
        end
    end

endmodule : fv_req_arbiter_rr_pick
`default_nettype wire

// File: rtl/fv_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fv_req_arbiter
// Description : Round-robin arbiter collecting FV read requests from the Edge
//               PEs and writing {valid, FV_addr, PE_tag} into the FV FIFO
//               through a single output register. Grants are combinational;
//               the granted request appears on wdata the following cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module fv_req_arbiter
    import fv_req_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_EDGE_PE,
    parameter int ADDR_W  = 8,
    parameter int TAG_W   = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [TAG_W:0]            num_active,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      wfull,
    output logic [ADDR_W+TAG_W:0]     wdata,
    output logic                      idle,
    output logic [ISSUED_CNT_W-1:0]   issued_cnt
);

    localparam int              WDATA_W     = 1 + ADDR_W + TAG_W;
    localparam logic [TAG_W:0]  C_NUM_REQ   = NUM_REQ[TAG_W:0];
    localparam logic [TAG_W:0]  C_ONE       = {{TAG_W{1'b0}}, 1'b1};

    arb_state_e                state_q;
    arb_state_e                state_d;
    logic [WDATA_W-1:0]        wdata_q;
    logic [WDATA_W-1:0]        wdata_d;
    logic [TAG_W-1:0]          rr_ptr_q;
    logic [TAG_W-1:0]          rr_ptr_d;
    logic [ISSUED_CNT_W-1:0]   issued_cnt_q;
    logic [ISSUED_CNT_W-1:0]   issued_cnt_d;

    logic [TAG_W:0]            num_act_eff;
    logic [TAG_W-1:0]          pick_idx;
    logic                      pick_found;
    logic                      wvalid;
    logic                      can_load;
    logic                      fifo_write;
    logic                      grant_en;
    logic [ADDR_W-1:0]         sel_addr;
    logic [TAG_W:0]            next_idx;

    assign wvalid     = wdata_q[WDATA_W-1];
    assign can_load   = !wvalid || !wfull;
    assign fifo_write = wvalid && !wfull;

    // Clamp the active count into 1..NUM_REQ so the picker never sees zero
    always_comb begin
        num_act_eff = num_active;
        if (num_active == '0) begin
            num_act_eff = C_ONE;
        end else if (num_active > C_NUM_REQ) begin
            num_act_eff = C_NUM_REQ;
        end
    end

    fv_req_arbiter_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .TAG_W   (TAG_W)
    ) u_rr_pick (
        .req_mask   (req_valid),
        .ptr        (rr_ptr_q),
        .num_active (num_act_eff),
        .grant_idx  (pick_idx),
        .found      (pick_found)
    );

    // Control state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; DRAIN waits for the output register to empty
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (enable) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!enable) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (enable) begin
                    state_d = ST_RUN;
                end else if (!wvalid || fifo_write) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Grant strobe and status outputs; reset suppresses any grant
    always_comb begin
        grant_en = !reset && (state_q == ST_RUN) && enable && can_load && pick_found;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_ready[i] = grant_en && (pick_idx == TAG_W'(i));
        end
        idle = (state_q == ST_IDLE) && !wvalid;
    end

    // Output register, pointer and write counter next values
    always_comb begin
        sel_addr = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == TAG_W'(i)) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
            end
        end
        next_idx     = {1'b0, pick_idx} + C_ONE;
        wdata_d      = wdata_q;
        rr_ptr_d     = rr_ptr_q;
        issued_cnt_d = issued_cnt_q + {{(ISSUED_CNT_W-1){1'b0}}, fifo_write};
        if (grant_en) begin
            wdata_d  = {1'b1, sel_addr, pick_idx};
            rr_ptr_d = (next_idx == num_act_eff) ? '0 : next_idx[TAG_W-1:0];
        end else if (fifo_write) begin
            wdata_d[WDATA_W-1] = 1'b0;
        end
    end

    // Datapath registers; reset discards any word still held for the FIFO
    always_ff @(posedge clk) begin
        if (reset) begin
            wdata_q      <= '0;
            rr_ptr_q     <= '0;
            issued_cnt_q <= '0;
        end else begin
            wdata_q      <= wdata_d;
            rr_ptr_q     <= rr_ptr_d;
            issued_cnt_q <= issued_cnt_d;
        end
    end

    assign wdata      = wdata_q;
    assign issued_cnt = issued_cnt_q;

endmodule : fv_req_arbiter
`default_nettype wire

// File: tb/tb_fv_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fv_req_arbiter
// Description : Directed self-checking bench for fv_req_arbiter with four
//               requesters and 8-bit addresses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fv_req_arbiter;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [2:0]  num_active;
    logic [3:0]  req_valid;
    logic [31:0] req_addr;
    logic [3:0]  req_ready;
    logic        wfull;
    logic [10:0] wdata;
    logic        idle;
    logic [15:0] issued_cnt;

    int n_checks = 0;
    int n_errors = 0;

    fv_req_arbiter #(
        .NUM_REQ (4),
        .ADDR_W  (8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .num_active (num_active),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .wfull      (wfull),
        .wdata      (wdata),
        .idle       (idle),
        .issued_cnt (issued_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] wd(input logic v, input logic [7:0] a, input logic [1:0] t);
        return {21'b0, v, a, t};
    endfunction

    initial begin
        reset      = 1'b1;
        enable     = 1'b0;
        num_active = 3'd4;
        req_valid  = 4'b0000;
        req_addr   = {8'h13, 8'h12, 8'h11, 8'h10};
        wfull      = 1'b0;
        step();
        step();

        // Reset state, with requests and enable already present
        req_valid = 4'b1111;
        enable    = 1'b1;
        #1;
        check("rst_wdata", 32'(wdata), 32'h0);
        check("rst_cnt", 32'(issued_cnt), 32'h0);
        check("rst_idle", 32'(idle), 32'h1);
        check("rst_ready", 32'(req_ready), 32'h0);

        reset = 1'b0;
        #1;
        check("idle_no_grant", 32'(req_ready), 32'h0);
        step();

        // Full round-robin sweep, one grant per cycle
        for (int i = 0; i < 5; i++) begin
            check("rr_ready", 32'(req_ready), 32'(4'b0001 << (i % 4)));
            step();
            check("rr_wdata", 32'(wdata), wd(1'b1, 8'(8'h10 + (i % 4)), 2'(i % 4)));
        end
        req_valid = 4'b0000;
        #1;
        check("rr_ready_none", 32'(req_ready), 32'h0);
        step();
        check("rr_cnt5", 32'(issued_cnt), 32'd5);
        check("rr_drained", 32'(wdata[10]), 32'h0);

        // Single requester PE2, then pointer lands on PE3
        req_valid          = 4'b0100;
        req_addr[23:16]    = 8'h40;
        #1;
        check("pe2_ready", 32'(req_ready), 32'h4);
        step();
        check("pe2_wdata", 32'(wdata), wd(1'b1, 8'h40, 2'd2));
        req_valid = 4'b1111;
        #1;
        check("ptr_after_pe2", 32'(req_ready), 32'h8);
        req_valid = 4'b0000;
        step();
        check("pe2_cnt", 32'(issued_cnt), 32'd6);

        // Stall with a tag-1 word pending under wfull
        req_valid = 4'b0010;
        #1;
        check("pe1_ready", 32'(req_ready), 32'h2);
        step();
        check("pe1_wdata", 32'(wdata), wd(1'b1, 8'h11, 2'd1));
        wfull     = 1'b1;
        req_valid = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("stall_ready", 32'(req_ready), 32'h0);
            step();
            check("stall_wdata", 32'(wdata), wd(1'b1, 8'h11, 2'd1));
            check("stall_cnt", 32'(issued_cnt), 32'd6);
        end
        wfull = 1'b0;
        #1;
        check("unstall_ready", 32'(req_ready), 32'h4);
        step();
        check("unstall_wdata", 32'(wdata), wd(1'b1, 8'h40, 2'd2));
        check("unstall_cnt", 32'(issued_cnt), 32'd7);
        req_valid = 4'b0000;
        step();
        check("unstall_cnt2", 32'(issued_cnt), 32'd8);

        // Two active requesters: 0,1,0,1 with PE2/PE3 requesting too
        num_active = 3'd2;
        req_valid  = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            #1;
            check("na2_ready", 32'(req_ready), (i % 2 == 0) ? 32'h1 : 32'h2);
            step();
            check("na2_wdata", 32'(wdata),
                  wd(1'b1, (i % 2 == 0) ? 8'h10 : 8'h11, 2'(i % 2)));
        end
        req_valid = 4'b0000;
        step();
        check("na2_cnt", 32'(issued_cnt), 32'd12);

        // num_active of zero behaves as one requester
        num_active = 3'd0;
        req_valid  = 4'b1110;
        #1;
        check("na0_ready_none", 32'(req_ready), 32'h0);
        req_valid  = 4'b1111;
        #1;
        check("na0_ready_pe0", 32'(req_ready), 32'h1);
        req_valid  = 4'b0000;
        num_active = 3'd4;
        #1;

        // Enable dropped with a word pending while the FIFO is full
        req_valid = 4'b0001;
        #1;
        check("drain_grant", 32'(req_ready), 32'h1);
        step();
        check("drain_wdata", 32'(wdata), wd(1'b1, 8'h10, 2'd0));
        req_valid = 4'b0000;
        wfull     = 1'b1;
        enable    = 1'b0;
        step();
        check("drain_idle0", 32'(idle), 32'h0);
        check("drain_hold", 32'(wdata), wd(1'b1, 8'h10, 2'd0));
        step();
        check("drain_idle0b", 32'(idle), 32'h0);
        wfull = 1'b0;
        step();
        check("drain_idle1", 32'(idle), 32'h1);
        check("drain_cnt", 32'(issued_cnt), 32'd13);
        check("drain_empty", 32'(wdata[10]), 32'h0);

        // Reset during a stall discards the pending word
        enable = 1'b1;
        step();
        req_valid = 4'b0010;
        #1;
        check("prerst_ready", 32'(req_ready), 32'h2);
        step();
        check("prerst_wdata", 32'(wdata), wd(1'b1, 8'h11, 2'd1));
        wfull     = 1'b1;
        req_valid = 4'b0000;
        step();
        check("prerst_hold", 32'(wdata), wd(1'b1, 8'h11, 2'd1));
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("postrst_wdata", 32'(wdata), 32'h0);
        check("postrst_cnt", 32'(issued_cnt), 32'h0);
        check("postrst_idle", 32'(idle), 32'h1);
        wfull     = 1'b0;
        req_valid = 4'b1111;
        #1;
        check("postrst_no_grant", 32'(req_ready), 32'h0);
        step();
        check("postrst_pe0", 32'(req_ready), 32'h1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_fv_req_arbiter
`default_nettype wire
